// File: rtl/vexriscv_ibus_rom_if.sv
// AXI4 read-only channel bundle (AR + R) between an instruction-bus master and the ROM bridge.
interface vexriscv_ibus_rom_if #(
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  // Read address channel
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;

  // Read data channel
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output arid, araddr, arlen, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/vexriscv_ibus_rom.sv
// AXI4 read-only slave that serves instruction bursts from a synchronous single-port ROM.
// One burst in flight; each beat is a ROM read cycle followed by a data cycle.
module vexriscv_ibus_rom #(
  parameter int unsigned C_S00_AXI_ID_WIDTH   = 1,
  parameter int unsigned C_S00_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_S00_AXI_DATA_WIDTH = 32,
  parameter int unsigned MEM_ADDR_WIDTH       = 12
) (
  input  logic                            clk,
  input  logic                            reset,
  vexriscv_ibus_rom_if.slave              s00_axi,
  output logic                            mem_en,
  output logic [MEM_ADDR_WIDTH-1:0]       mem_addr,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned ID_W   = C_S00_AXI_ID_WIDTH;
  localparam int unsigned ADDR_W = C_S00_AXI_ADDR_WIDTH;
  localparam int unsigned MEM_W  = MEM_ADDR_WIDTH;
  localparam int unsigned LEN_W  = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  logic [1:0]        state_q,   state_d;
  logic [ID_W-1:0]   id_q,      id_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [LEN_W-1:0]  len_q,     len_d;
  logic [1:0]        burst_q,   burst_d;
  logic [LEN_W-1:0]  beat_q,    beat_d;
  logic              arready_q, arready_d;
  logic              rvalid_q,  rvalid_d;
  logic              rlast_q,   rlast_d;
  logic              mem_en_q,  mem_en_d;

  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] wrap_mask;
  logic [ADDR_W-1:0] addr_next;

  // Address of the following beat; reserved burst type 2'b11 behaves as INCR
  always_comb begin
    addr_inc  = addr_q + ADDR_W'(4);
    wrap_mask = ADDR_W'({len_q, 2'b11});
    addr_next = addr_inc;
    case (burst_q)
      BURST_FIXED: addr_next = addr_q;
      BURST_WRAP:  addr_next = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
      default:     addr_next = addr_inc;
    endcase
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    burst_d   = burst_q;
    beat_d    = beat_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    mem_en_d  = mem_en_q;

    case (state_q)
      ST_IDLE: begin
        arready_d = 1'b1;
        rvalid_d  = 1'b0;
        rlast_d   = 1'b0;
        mem_en_d  = 1'b0;
        if (s00_axi.arvalid) begin
          id_d      = s00_axi.arid;
          addr_d    = s00_axi.araddr;
          len_d     = s00_axi.arlen;
          burst_d   = s00_axi.arburst;
          beat_d    = '0;
          arready_d = 1'b0;
          mem_en_d  = 1'b1;
          state_d   = ST_READ;
        end
      end

      // ROM samples mem_addr at the end of this cycle
      ST_READ: begin
        mem_en_d = 1'b0;
        rvalid_d = 1'b1;
        rlast_d  = (beat_q == len_q);
        state_d  = ST_DATA;
      end

      // Beat presented; hold everything until the master takes it
      ST_DATA: begin
        if (s00_axi.rready) begin
          beat_d   = beat_q + LEN_W'(1);
          addr_d   = addr_next;
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
          if (rlast_q) begin
            arready_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            mem_en_d = 1'b1;
            state_d  = ST_READ;
          end
        end
      end

      default: begin
        arready_d = 1'b1;
        rvalid_d  = 1'b0;
        rlast_d   = 1'b0;
        mem_en_d  = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      burst_q   <= '0;
      beat_q    <= '0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      mem_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      burst_q   <= burst_d;
      beat_q    <= beat_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      mem_en_q  <= mem_en_d;
    end
  end

  // ROM data passes straight through; the ROM holds it while mem_en is low
  assign s00_axi.arready = arready_q;
  assign s00_axi.rid     = id_q;
  assign s00_axi.rdata   = mem_rdata;
  assign s00_axi.rresp   = 2'b00;
  assign s00_axi.rlast   = rlast_q;
  assign s00_axi.rvalid  = rvalid_q;
  assign mem_en          = mem_en_q;
  assign mem_addr        = addr_q[MEM_W+1:2];

endmodule

// File: tb/tb_vexriscv_ibus_rom.sv
// Directed bench for vexriscv_ibus_rom with a behavioural synchronous ROM.
module tb_vexriscv_ibus_rom;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_en;
  logic [11:0] mem_addr;
  logic [31:0] mem_rdata = 32'h0;

  int errors = 0;
  int checks = 0;

  logic [11:0] exp_q [$];

  vexriscv_ibus_rom_if #(.ID_WIDTH(1), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  vexriscv_ibus_rom #(
    .C_S00_AXI_ID_WIDTH  (1),
    .C_S00_AXI_ADDR_WIDTH(32),
    .C_S00_AXI_DATA_WIDTH(32),
    .MEM_ADDR_WIDTH      (12)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .s00_axi  (bus),
    .mem_en   (mem_en),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // ROM: word at address a holds C0DE_0000 | a, one-cycle read latency
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= 32'hC0DE_0000 | 32'(mem_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One burst, checking every cycle; exp_q holds the expected word addresses
  task automatic do_burst(input logic id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int stall_beat, input int stall_n,
                          input bit hold_ar);
    chk("arready_idle", 32'(bus.arready), 32'd1);
    bus.arid    = id;
    bus.araddr  = addr;
    bus.arlen   = len;
    bus.arburst = burst;
    bus.arvalid = 1'b1;
    bus.rready  = 1'b1;
    tick();
    if (!hold_ar) bus.arvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      chk("read_mem_en", 32'(mem_en), 32'd1);
      chk("read_mem_addr", 32'(mem_addr), 32'(exp_q[b]));
      chk("read_arready", 32'(bus.arready), 32'd0);
      chk("read_rvalid", 32'(bus.rvalid), 32'd0);
      tick();
      chk("data_rvalid", 32'(bus.rvalid), 32'd1);
      chk("data_rdata", bus.rdata, 32'hC0DE_0000 | 32'(exp_q[b]));
      chk("data_rlast", 32'(bus.rlast), 32'(b == int'(len)));
      chk("data_rid", 32'(bus.rid), 32'(id));
      chk("data_rresp", 32'(bus.rresp), 32'd0);
      chk("data_mem_en", 32'(mem_en), 32'd0);
      chk("data_arready", 32'(bus.arready), 32'd0);
      if (b == stall_beat) begin
        bus.rready = 1'b0;
        repeat (stall_n) begin
          tick();
          chk("stall_rvalid", 32'(bus.rvalid), 32'd1);
          chk("stall_rdata", bus.rdata, 32'hC0DE_0000 | 32'(exp_q[b]));
          chk("stall_rlast", 32'(bus.rlast), 32'(b == int'(len)));
          chk("stall_mem_en", 32'(mem_en), 32'd0);
        end
        bus.rready = 1'b1;
      end
      tick();
    end
    chk("end_arready", 32'(bus.arready), 32'd1);
    chk("end_rvalid", 32'(bus.rvalid), 32'd0);
    chk("end_rlast", 32'(bus.rlast), 32'd0);
    chk("end_mem_en", 32'(mem_en), 32'd0);
  endtask

  // Directed sequence
  initial begin
    reset       = 1'b1;
    bus.arid    = 1'b0;
    bus.araddr  = 32'h0;
    bus.arlen   = 8'h0;
    bus.arburst = 2'b01;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_arready", 32'(bus.arready), 32'd1);
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_rlast", 32'(bus.rlast), 32'd0);
    chk("rst_rid", 32'(bus.rid), 32'd0);
    chk("rst_rresp", 32'(bus.rresp), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);

    // Single beat
    exp_q = '{12'h040};
    do_burst(1'b1, 32'h0000_0100, 8'd0, 2'b01, -1, 0, 1'b0);

    // INCR 8 beats
    exp_q = '{12'h008, 12'h009, 12'h00A, 12'h00B, 12'h00C, 12'h00D, 12'h00E, 12'h00F};
    do_burst(1'b0, 32'h0000_0020, 8'd7, 2'b01, -1, 0, 1'b0);

    // WRAP 4 beats, 16-byte boundary
    exp_q = '{12'h00E, 12'h00F, 12'h00C, 12'h00D};
    do_burst(1'b1, 32'h0000_0038, 8'd3, 2'b10, -1, 0, 1'b0);

    // WRAP 2 beats, 8-byte boundary
    exp_q = '{12'h003, 12'h002};
    do_burst(1'b0, 32'h0000_000C, 8'd1, 2'b10, -1, 0, 1'b0);

    // FIXED
    exp_q = '{12'h011, 12'h011, 12'h011};
    do_burst(1'b1, 32'h0000_0044, 8'd2, 2'b00, -1, 0, 1'b0);

    // Aliased high bits and ignored byte offset
    exp_q = '{12'h001};
    do_burst(1'b0, 32'hFFFF_4007, 8'd0, 2'b01, -1, 0, 1'b0);

    // Reserved burst type behaves as INCR
    exp_q = '{12'h1FF, 12'h200};
    do_burst(1'b1, 32'h0000_07FC, 8'd1, 2'b11, -1, 0, 1'b0);

    // Backpressure on beat 2 for 3 cycles
    exp_q = '{12'h020, 12'h021, 12'h022, 12'h023};
    do_burst(1'b0, 32'h0000_0080, 8'd3, 2'b01, 1, 3, 1'b0);

    // Overlap: arvalid held through a burst, second burst follows in IDLE
    exp_q = '{12'h100, 12'h101, 12'h102};
    do_burst(1'b1, 32'h0000_0400, 8'd2, 2'b01, -1, 0, 1'b1);
    exp_q = '{12'h080, 12'h081};
    do_burst(1'b0, 32'h0000_0200, 8'd1, 2'b01, -1, 0, 1'b0);

    // Reset during beat 3 of INCR len 7
    bus.arid    = 1'b1;
    bus.araddr  = 32'h0000_0300;
    bus.arlen   = 8'd7;
    bus.arburst = 2'b01;
    bus.arvalid = 1'b1;
    bus.rready  = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      chk("pre_rst_mem_addr", 32'(mem_addr), 32'h0C0 + 32'(b));
      tick();
      chk("pre_rst_rvalid", 32'(bus.rvalid), 32'd1);
      tick();
    end
    chk("beat3_mem_en", 32'(mem_en), 32'd1);
    chk("beat3_mem_addr", 32'(mem_addr), 32'h0C2);
    tick();
    chk("beat3_rvalid", 32'(bus.rvalid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("mid_rst_arready", 32'(bus.arready), 32'd1);
    chk("mid_rst_rlast", 32'(bus.rlast), 32'd0);
    chk("mid_rst_mem_en", 32'(mem_en), 32'd0);
    chk("mid_rst_rid", 32'(bus.rid), 32'd0);
    exp_q = '{12'h000};
    do_burst(1'b1, 32'h0000_0000, 8'd0, 2'b01, -1, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vexriscv_ibus_rom.md
VEXRISCV_IBUS_ROM -- requirements
Module: vexriscv_ibus_rom

Interface
REQ-001 SHALL have parameter C_S00_AXI_ID_WIDTH, default 1, AXI ID width.
REQ-002 SHALL have parameter C_S00_AXI_ADDR_WIDTH, default 32, AXI byte-address width.
REQ-003 SHALL have parameter C_S00_AXI_DATA_WIDTH, default 32, data width; only the value 32 is supported.
REQ-004 SHALL have parameter MEM_ADDR_WIDTH, default 12, ROM word-address width.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-007 SHALL have port s00_axi_arid, input, C_S00_AXI_ID_WIDTH, read burst ID.
REQ-008 SHALL have port s00_axi_araddr, input, C_S00_AXI_ADDR_WIDTH, burst start byte address.
REQ-009 SHALL have port s00_axi_arlen, input, 8, beats minus one.
REQ-010 SHALL have port s00_axi_arburst, input, 2, burst type: 00 FIXED, 01 INCR, 10 WRAP.
REQ-011 SHALL have port s00_axi_arvalid, input, 1, address valid.
REQ-012 SHALL have port s00_axi_arready, output, 1, address accepted.
REQ-013 SHALL have port s00_axi_rid, output, C_S00_AXI_ID_WIDTH, echoed burst ID.
REQ-014 SHALL have port s00_axi_rdata, output, 32, read data.
REQ-015 SHALL have port s00_axi_rresp, output, 2, response; constant 2'b00 (OKAY).
REQ-016 SHALL have port s00_axi_rlast, output, 1, final beat of the burst.
REQ-017 SHALL have port s00_axi_rvalid, output, 1, read data valid.
REQ-018 SHALL have port s00_axi_rready, input, 1, master accepts the beat.
REQ-019 SHALL have port mem_en, output, 1, ROM read enable; ROM output is held while mem_en=0.
REQ-020 SHALL have port mem_addr, output, MEM_ADDR_WIDTH, ROM word address.
REQ-021 SHALL have port mem_rdata, input, 32, ROM data, valid one cycle after mem_en=1.

Function
REQ-022 SHALL implement FSM IDLE -> READ -> DATA, with DATA -> READ (more beats) or DATA -> IDLE (last beat).
REQ-023 SHALL drive arready=1 only in IDLE, and SHALL accept at most one burst outstanding.
REQ-024 SHALL, on an AR handshake in IDLE: latch arid, araddr, arlen and arburst; clear the beat counter; go to READ.
REQ-025 SHALL, in READ, assert mem_en=1 for exactly one cycle with mem_addr=addr[MEM_ADDR_WIDTH+1:2], then go to DATA.
REQ-026 SHALL, in DATA, assert rvalid=1 with rdata=mem_rdata (combinational) and rid=the latched ID.
REQ-027 SHALL assert rlast=1 only in DATA when beat counter==latched arlen.
REQ-028 SHALL hold rvalid, rdata, rlast and rid stable and keep mem_en=0 while rvalid=1 and rready=0.
REQ-029 SHALL, on an rvalid&rready beat, increment the beat counter and update the address per burst type.
REQ-030 SHALL use these address updates: FIXED, unchanged; INCR, addr+4; reserved 2'b11, treated as INCR.
REQ-031 SHALL, for WRAP, use wrap size (arlen+1)*4 bytes (arlen in {1,3,7,15}), keep the upper address bits, and set the lower bits to (addr+4) mod wrap size.
REQ-032 SHALL take 1 cycle from AR handshake to mem_en and 2 cycles to the first rvalid; each beat takes 2 cycles minimum; an N-beat burst with rready=1 takes 2N cycles to IDLE.
REQ-033 SHALL ignore address bits above MEM_ADDR_WIDTH+1 (ROM aliases) and address bits [1:0].
REQ-034 SHALL ignore arvalid outside IDLE; an arvalid asserted in the same cycle that the last beat completes is accepted on the next cycle, in IDLE.

Reset
REQ-035 SHALL, on any clock edge with reset=1, including mid-burst, enter IDLE and discard the burst.
REQ-036 SHALL, after reset: arready=1, rvalid=0, rlast=0, rid=0, rresp=0, mem_en=0, mem_addr=0, beat counter=0.

Verification
REQ-037 SHALL verify a single beat: araddr=0x100, arlen=0, arid=1 -> mem_en with mem_addr=0x040 at cycle+1; rvalid, rlast=1 and rid=1 at cycle+2; arready=1 at cycle+3.
REQ-038 SHALL verify INCR: araddr=0x20, arlen=7, rready=1 -> mem_addr 0x08..0x0F in sequence, 8 beats, rlast only on beat 8, IDLE 16 cycles after the handshake.
REQ-039 SHALL verify WRAP: araddr=0x38, arlen=3 -> mem_addr 0x0E, 0x0F, 0x0C, 0x0D; rlast on the 4th beat.
REQ-040 SHALL verify backpressure: rready=0 for 3 cycles on beat 2 of INCR len=3 -> rvalid/rdata/rlast stable, no mem_en pulse, the burst then completes correctly.
REQ-041 SHALL verify overlap: arvalid held high during a burst -> arready=0 until after the last beat; the second burst is then accepted with the correct rid.
REQ-042 SHALL verify reset: reset=1 for 1 cycle during beat 3 of INCR len=7 -> next cycle rvalid=0 and arready=1; a new burst from 0x0 returns mem_addr 0x00.
